// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the Naive_CPU pipeline sequencer:
// the stall bus layout, canned stall patterns and the debug FSM encoding.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ADDR_W  = 16;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [ADDR_W-1:0]  inst_addr_t;

  // stall[0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved
  localparam stall_bus_t STALL_NONE  = 6'b000000;
  localparam stall_bus_t STALL_FETCH = 6'b000011;
  localparam stall_bus_t STALL_ID    = 6'b000111;
  localparam stall_bus_t STALL_EX    = 6'b001111;

  localparam int STALL_IF_ID_BIT = 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2,
    ST_STEP    = 2'd3
  } dbg_state_e;

  // Priority: EX busy over ID load-use over whatever the debug state wants.
  function automatic stall_bus_t base_stall(input logic       req_ex,
                                            input logic       req_id,
                                            input dbg_state_e st);
    stall_bus_t s;
    if (req_ex) begin
      s = STALL_EX;
    end else if (req_id) begin
      s = STALL_ID;
    end else if (st == ST_HALTING || st == ST_HALTED) begin
      s = STALL_FETCH;
    end else begin
      s = STALL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Watchdog on EX multi-cycle stalls: counts consecutive busy cycles,
// saturates at TIMEOUT and raises a sticky error when it gets there.
module pipe_ctrl_stall_wdt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic stall_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wdt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt   <= '0;
      stall_err <= 1'b0;
    end else if (busy) begin
      if (wdt_cnt != CNT_MAX) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      // Error lands on the same edge the count reaches TIMEOUT.
      if (wdt_cnt == CNT_LAST) begin
        stall_err <= 1'b1;
      end
    end else begin
      wdt_cnt <= '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges ID/EX stall requests into the per-stage
// stall vector, turns issued taken branches into flush + redirect, and runs
// the debug run/halt/single-step FSM plus the EX stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC     = 3,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  input  logic        dbg_resume,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        new_pc_valid,
  output logic [15:0] new_pc,
  output logic        halted,
  output logic        step_done,
  output logic        stall_err,
  output logic [1:0]  dbg_state
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(1);

  dbg_state_e    state;
  logic [DW-1:0] drain_cnt;
  logic          drain_from_step;

  stall_bus_t    stall_base;
  logic          issue;
  logic          branch_ok;

  // Valid/ready view of the IF/ID -> ID/EX hand-off: the ID instruction is
  // offered every cycle and is consumed only when stall[1] is low; a taken
  // branch is acted on only in that consuming cycle, otherwise ID re-offers.
  always_comb begin
    stall_base = base_stall(stallreq_ex, stallreq_id, state);
    issue      = ~stall_base[STALL_IF_ID_BIT];
    branch_ok  = branch_taken & issue;

    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = '0;
    if (!rst) begin
      stall        = stall_base;
      flush        = branch_ok;
      new_pc_valid = branch_ok;
      new_pc       = branch_ok ? branch_target : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RUN;
      drain_cnt       <= '0;
      drain_from_step <= 1'b0;
      halted          <= 1'b0;
      step_done       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (dbg_halt) begin
            state           <= ST_HALTING;
            drain_cnt       <= DRAIN_LOAD;
            drain_from_step <= 1'b0;
          end
        end
        ST_HALTING: begin
          // The pipe only drains on cycles EX is actually moving.
          if (!stallreq_ex) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= ST_HALTED;
              halted    <= 1'b1;
              step_done <= drain_from_step;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (dbg_resume) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end else if (dbg_step) begin
            state  <= ST_STEP;
            halted <= 1'b0;
          end
        end
        ST_STEP: begin
          if (issue) begin
            state           <= ST_HALTING;
            drain_cnt       <= DRAIN_LOAD;
            drain_from_step <= 1'b1;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  pipe_ctrl_stall_wdt #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_stall_wdt (
    .clk       (clk),
    .rst       (rst),
    .busy      (stallreq_ex),
    .stall_err (stall_err)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage Naive_CPU (if_pc, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Collects stall requests from ID (load-use) and EX (multi-cycle ALU op) and turns them into a per-stage stall vector.
- Turns ID-resolved taken branches into a flush plus a PC redirect.
- Adds a debug run/halt/single-step FSM and a stall watchdog.
- Sits beside the datapath in Naive_CPU; drives every pipeline register and if_pc.

Parameters:
DRAIN_CYC, 3, cycles of bubble injection needed to empty ID/EX, EX/MEM and MEM/WB after fetch stops.
STALL_TIMEOUT, 16, consecutive stallreq_ex cycles after which stall_err sets.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stallreq_id  in  1  ID load-use hazard; hold IF/ID, bubble into ID/EX
stallreq_ex  in  1  EX multi-cycle op busy; hold ID/EX, bubble into EX/MEM
branch_taken  in  1  ID resolved a taken branch/jump this cycle
branch_target  in  16  `InstAddrBus target address from ID
dbg_halt  in  1  request halt (level, sampled each cycle)
dbg_step  in  1  single-step request while halted
dbg_resume  in  1  resume free run while halted
stall  out  6  `StallBus; [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (0)
flush  out  1  clear IF/ID this edge (wrong-path fetch)
new_pc_valid  out  1  if_pc loads new_pc this edge
new_pc  out  16  redirect address
halted  out  1  registered; FSM in HALTED
step_done  out  1  registered; 1-cycle pulse on return to HALTED after a step
stall_err  out  1  registered; sticky watchdog error

Behaviour:
- Stall convention: stall[i]=1 freezes stage i; stall[i]=1 with stall[i+1]=0 injects a bubble (wreg=0, NOP) into stage i+1.
- stall, flush, new_pc_valid, new_pc are combinational from inputs and registered state (same-cycle effect). halted, step_done, stall_err are registered.
- Reset (rst=1 at edge): state RUN, drain_cnt=0, wdt_cnt=0. halted, step_done, stall_err =0. While rst=1, combinational outputs are forced 0.
- FSM states: RUN, HALTING, HALTED, STEP.
- Base stall by priority, in every state:
  - stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else the state value: RUN/STEP 6'b000000; HALTING/HALTED 6'b000011.
- Branch accepted only when the final stall[1]==0, i.e. the ID instruction actually issues. Then flush=1, new_pc_valid=1, new_pc=branch_target. Otherwise branch_taken is ignored; ID re-presents it later.
- RUN -> HALTING when dbg_halt=1. A branch in the same cycle is still honoured. drain_cnt loads DRAIN_CYC.
- HALTING:
  - drain_cnt decrements only on cycles with stallreq_ex=0.
  - Goes to HALTED on the edge where drain_cnt==1 and it decrements.
  - IF/ID keeps its unissued instruction.
- HALTED:
  - dbg_resume -> RUN. dbg_resume wins over dbg_step in the same cycle.
  - dbg_step -> STEP.
  - halted=1 in this state only.
- STEP: one cycle with state stall 0, so exactly one instruction issues from IF/ID and one is fetched. Then HALTING with drain_cnt=DRAIN_CYC.
  - If stallreq_* holds STEP, it stays in STEP until the issue cycle completes (final stall[1]==0).
- step_done=1 for exactly one cycle, the first cycle in HALTED after a STEP-originated drain.
- dbg_halt in HALTING/HALTED/STEP: ignored. dbg_step/dbg_resume outside HALTED: ignored.
- Watchdog:
  - wdt_cnt increments on each cycle with stallreq_ex=1, clears on any cycle with it 0, saturates at STALL_TIMEOUT.
  - stall_err sets on the edge where wdt_cnt reaches STALL_TIMEOUT and stays set until rst.
  - Width $clog2(STALL_TIMEOUT+1).
- Reset mid-halt/step returns to RUN with all registered outputs 0 on the next cycle.

Decomposition:
- defines.sv gains:
  - `StallBus 5:0
  - stall constants `StallNone 6'b000000, `StallId 6'b000111, `StallEx 6'b001111, `StallFetch 6'b000011
  - `DbgStateBus plus state encodings RUN/HALTING/HALTED/STEP
- One sub-module: stall_wdt (saturating watchdog counter plus sticky error flag), instantiated once.

Test Plan:
1. Reset then stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle only; next cycle 6'b000000; halted/stall_err=0.
2. stallreq_ex=1 and stallreq_id=1 and branch_taken=1, target 16'h0040 -> stall=6'b001111, flush=0, new_pc_valid=0. Next cycle, no stalls and branch_taken=1 -> flush=1, new_pc=16'h0040.
3. dbg_halt in RUN with branch_taken, target 16'h0020 -> flush=1 that cycle. stall=6'b000011 for 3 cycles, then halted=1 on cycle 4, stall stays 6'b000011.
4. In HALTED pulse dbg_step -> one cycle stall=6'b000000, 3 drain cycles, step_done=1 for exactly 1 cycle when halted reasserts. Then dbg_step+dbg_resume together -> RUN, step_done stays 0.
5. stallreq_ex held 16 cycles (STALL_TIMEOUT=16) -> stall_err=1 after the 16th edge and stays 1 after stallreq_ex drops. 15 cycles, drop, 15 cycles -> stall_err=0.
6. rst=1 for one cycle while in HALTING with drain_cnt=2 -> next cycle state RUN, stall=0, halted=0. stall_err cleared.
